// File: rtl/vector_player.sv
// Timed vector playback engine: stores (tick, channel-data) vectors while idle,
// then applies each vector to ch_out when the playback tick counter reaches its stamp.
module vector_player #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 16,
   parameter int DEPTH  = 64,
   parameter int TICK_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ld_valid,
   input  logic [TICK_W-1:0]         ld_tick,
   input  logic [NUM_CH*CH_W-1:0]    ld_data,
   output logic                      ld_ready,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      clear,
   input  logic                      loop_en,
   input  logic                      advance,
   output logic [NUM_CH*CH_W-1:0]    ch_out,
   output logic                      ch_strobe,
   output logic                      busy,
   output logic                      done,
   output logic [TICK_W-1:0]         cur_tick,
   output logic [$clog2(DEPTH)-1:0]  vec_idx,
   output logic [15:0]               loop_cnt,
   output logic                      err_ovf,
   output logic                      err_order
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = IDX_W + 1;
   localparam int DATA_W = NUM_CH * CH_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [TICK_W-1:0] last_tick;

   logic [TICK_W-1:0] tick_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic             ld_full;
   logic             ld_misorder;
   logic             ld_accept;
   logic             can_start;
   logic             match;
   logic             is_last;
   logic             next_same;
   logic [IDX_W-1:0] idx_next;

   always_comb begin
      ld_full     = (count == CNT_W'(DEPTH));
      ld_ready    = (state == S_IDLE) && !ld_full;
      ld_misorder = (count != '0) && (ld_tick < last_tick);
      ld_accept   = ld_ready && ld_valid && !clear && !ld_misorder;
      can_start   = (state != S_RUN) && start && !clear && (count != '0);
      idx_next    = vec_idx + 1'b1;
      match       = (tick_mem[vec_idx] == cur_tick);
      is_last     = ({1'b0, vec_idx} == (count - 1'b1));
      // only consulted when vec_idx is not the last entry, so idx_next is in range
      next_same   = (tick_mem[idx_next] == cur_tick);
   end

   // Vector storage is intentionally not reset; count gates every access.
   always_ff @(posedge clk) begin
      if (ld_accept) begin
         tick_mem[count[IDX_W-1:0]] <= ld_tick;
         data_mem[count[IDX_W-1:0]] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         last_tick <= '0;
         vec_idx   <= '0;
         cur_tick  <= '0;
         loop_cnt  <= '0;
         ch_out    <= '0;
         ch_strobe <= 1'b0;
         err_ovf   <= 1'b0;
         err_order <= 1'b0;
      end else begin
         ch_strobe <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (clear) begin
                  count     <= '0;
                  err_ovf   <= 1'b0;
                  err_order <= 1'b0;
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b0;
               end else begin
                  if (state == S_IDLE && ld_valid) begin
                     if (ld_full) begin
                        err_ovf <= 1'b1;
                     end else if (ld_misorder) begin
                        err_order <= 1'b1;
                     end else begin
                        count     <= count + 1'b1;
                        last_tick <= ld_tick;
                     end
                  end
                  if (can_start) begin
                     state    <= S_RUN;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     cur_tick <= '0;
                     vec_idx  <= '0;
                     loop_cnt <= '0;
                  end
               end
            end

            S_RUN: begin
               if (stop) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (advance) begin
                  if (match) begin
                     ch_out    <= data_mem[vec_idx];
                     ch_strobe <= 1'b1;
                     if (is_last) begin
                        if (loop_en) begin
                           vec_idx  <= '0;
                           cur_tick <= '0;
                           if (loop_cnt != '1)
                              loop_cnt <= loop_cnt + 1'b1;
                        end else begin
                           state    <= S_DONE;
                           busy     <= 1'b0;
                           done     <= 1'b1;
                           cur_tick <= cur_tick + 1'b1;
                        end
                     end else begin
                        vec_idx <= idx_next;
                        // equal-stamp vectors are applied on back-to-back cycles at the same tick
                        if (!next_same)
                           cur_tick <= cur_tick + 1'b1;
                     end
                  end else begin
                     cur_tick <= cur_tick + 1'b1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
